// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32 store unit: lane-aligns SB/SH/SW into one or two DMEM write beats.
// Optional macro STORE_MISALIGN_SPLIT_EN enables misaligned stores split across two words.
module store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_st_valid,
   output logic              o_st_ready,
   input  logic [ADDR_W-1:0] i_st_addr,
   input  logic [31:0]       i_st_data,
   input  logic [2:0]        i_st_type,
   output logic              o_mem_req,
   input  logic              i_mem_ack,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   output logic              o_err
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_bmask;
   logic [31:0]       r_hi_wdata;
   logic [3:0]        r_hi_bmask;
   logic              r_err;

   logic              w_accept;
   logic [1:0]        w_off;
   logic [3:0]        w_base;
   logic [7:0]        w_mask;
   logic [31:0]       w_src;
   logic [63:0]       w_data64;
   logic              w_type_ok;
   logic              w_align_ok;
   logic              w_legal;
   logic              w_split;
   logic [ADDR_W-1:0] w_word_addr;

   assign w_accept    = i_st_valid && (r_state == IDLE);
   assign w_off       = i_st_addr[1:0];
   assign w_word_addr = {i_st_addr[ADDR_W-1:2], 2'b00};
   assign w_type_ok   = (i_st_type == 3'b000) || (i_st_type == 3'b001) || (i_st_type == 3'b010);
   assign w_split     = (r_hi_bmask != 4'b0000);

`ifdef STORE_MISALIGN_SPLIT_EN
   assign w_align_ok = 1'b1;
`else
   assign w_align_ok = !((i_st_type == 3'b001) && w_off[0]) &&
                       !((i_st_type == 3'b010) && (w_off != 2'b00));
`endif

   assign w_legal = w_type_ok && w_align_ok;

   always_comb begin
      w_base = 4'b0000;
      w_src  = 32'd0;
      case (i_st_type)
         3'b000: begin
            w_base = 4'b0001;
            w_src  = {4{i_st_data[7:0]}};
         end
         3'b001: begin
            w_base = 4'b0011;
            w_src  = {16'd0, i_st_data[15:0]};
         end
         3'b010: begin
            w_base = 4'b1111;
            w_src  = i_st_data;
         end
         default: begin
            w_base = 4'b0000;
            w_src  = 32'd0;
         end
      endcase
   end

   assign w_mask = {4'b0000, w_base} << w_off;
   // Bytes are replicated across all lanes, so only wider stores need shifting.
   assign w_data64 = (i_st_type == 3'b000) ? {32'd0, w_src}
                                           : ({32'd0, w_src} << {w_off, 3'b000});

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && w_legal) w_next = BEAT0;
         BEAT0:   if (i_mem_ack) w_next = w_split ? BEAT1 : IDLE;
         BEAT1:   if (i_mem_ack) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_mem_bmask <= 4'b0000;
         r_hi_wdata  <= 32'd0;
         r_hi_bmask  <= 4'b0000;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_accept && !w_legal;
         case (r_state)
            IDLE: begin
               if (w_accept && w_legal) begin
                  r_mem_addr  <= w_word_addr;
                  r_mem_wdata <= w_data64[31:0];
                  r_mem_bmask <= w_mask[3:0];
                  r_hi_wdata  <= w_data64[63:32];
                  r_hi_bmask  <= w_mask[7:4];
               end
            end
            BEAT0: begin
               if (i_mem_ack) begin
                  if (w_split) begin
                     r_mem_addr  <= r_mem_addr + ADDR_W'(4);
                     r_mem_wdata <= r_hi_wdata;
                     r_mem_bmask <= r_hi_bmask;
                     r_hi_bmask  <= 4'b0000;
                  end else begin
                     r_mem_bmask <= 4'b0000;
                  end
               end
            end
            BEAT1: begin
               if (i_mem_ack) r_mem_bmask <= 4'b0000;
            end
            default: r_mem_bmask <= 4'b0000;
         endcase
      end
   end

   assign o_st_ready  = (r_state == IDLE);
   assign o_mem_req   = (r_state != IDLE);
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_bmask = r_mem_bmask;
   assign o_err       = r_err;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit; honours STORE_MISALIGN_SPLIT_EN.
module tb_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = 32'd0;
   logic [31:0] st_data = 32'd0;
   logic [2:0]  st_type = 3'd0;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_bmask;
   logic        err;

   store_unit #(.ADDR_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_st_valid(st_valid), .o_st_ready(st_ready),
      .i_st_addr(st_addr), .i_st_data(st_data), .i_st_type(st_type),
      .o_mem_req(mem_req), .i_mem_ack(mem_ack),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
      .o_err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } beat_t;

   beat_t beat_q[$];
   bit    err_q[$];
   int    checks = 0;
   int    failures = 0;
   int    ack_mode = 1;   // 0 random, 1 always, 2 after 3 req cycles, 3 never

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: walk the stored bytes one by one and group them by destination word.
   function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      int    size;
      bit    legal;
      beat_t b[2];
      logic [31:0] ba;
      int    k;
      legal = (t <= 3'd2);
`ifndef STORE_MISALIGN_SPLIT_EN
      if (t == 3'd1 && a[0]) legal = 0;
      if (t == 3'd2 && a[1:0] != 2'b00) legal = 0;
`endif
      if (!legal) begin
         err_q.push_back(1'b1);
         return;
      end
      size = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
      for (int j = 0; j < 2; j++) begin
         b[j].addr = (a & 32'hFFFF_FFFC) + 32'(4 * j);
         b[j].data = (t == 3'd0) ? {4{d[7:0]}} : 32'd0;
         b[j].mask = 4'b0000;
      end
      for (int i = 0; i < size; i++) begin
         ba = a + 32'(i);
         k  = ((ba & 32'hFFFF_FFFC) == b[0].addr) ? 0 : 1;
         b[k].data[ba[1:0]*8 +: 8] = d[i*8 +: 8];
         b[k].mask[ba[1:0]] = 1'b1;
      end
      beat_q.push_back(b[0]);
      if (b[1].mask != 4'b0000) beat_q.push_back(b[1]);
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                        input bit use_model);
      int guard = 0;
      @(negedge clk);
      while (!st_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) chk("ready_timeout", 64'(st_ready), 64'd1);
      if (use_model) model(a, d, t);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_type  = t;
      @(negedge clk);
      st_valid = 1'b0;
      st_addr  = $urandom;
      st_data  = $urandom;
      st_type  = 3'($urandom);
   endtask

   task automatic exp_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      beat_t b;
      b.addr = a;
      b.data = d;
      b.mask = m;
      beat_q.push_back(b);
   endtask

   // Ack driver
   initial begin
      int  cnt = 0;
      bit  prev_fire = 0;
      forever begin
         @(negedge clk);
         cnt = mem_req ? (prev_fire ? 1 : cnt + 1) : 0;
         case (ack_mode)
            0:       mem_ack = 1'($urandom);
            1:       mem_ack = 1'b1;
            2:       mem_ack = (cnt >= 3);
            default: mem_ack = 1'b0;
         endcase
         prev_fire = mem_req && mem_ack;
      end
   end

   // Monitor
   initial begin
      bit    m_prev_req = 0;
      bit    m_prev_fire = 0;
      beat_t held;
      beat_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            m_prev_req  = 0;
            m_prev_fire = 0;
         end else begin
            if (err) begin
               chk("err_expected", 64'(err_q.size() > 0), 64'd1);
               if (err_q.size() > 0) void'(err_q.pop_front());
            end
            if (!mem_req) begin
               chk("idle_bmask", 64'(mem_bmask), 64'd0);
            end else if (m_prev_req && !m_prev_fire) begin
               chk("stable_addr", 64'(mem_addr), 64'(held.addr));
               chk("stable_wdata", 64'(mem_wdata), 64'(held.data));
               chk("stable_bmask", 64'(mem_bmask), 64'(held.mask));
            end
            if (mem_req && mem_ack) begin
               chk("beat_expected", 64'(beat_q.size() > 0), 64'd1);
               if (beat_q.size() > 0) begin
                  e = beat_q.pop_front();
                  chk("beat_addr", 64'(mem_addr), 64'(e.addr));
                  chk("beat_wdata", 64'(mem_wdata), 64'(e.data));
                  chk("beat_bmask", 64'(mem_bmask), 64'(e.mask));
               end
            end
            held.addr   = mem_addr;
            held.data   = mem_wdata;
            held.mask   = mem_bmask;
            m_prev_req  = mem_req;
            m_prev_fire = mem_req && mem_ack;
         end
      end
   end

   initial begin
      int guard;
      logic [31:0] ra;
      logic [2:0]  rt;
      #2;
      chk("rst_ready", 64'(st_ready), 64'd1);
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_bmask", 64'(mem_bmask), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // SB into lane 3, ack immediately, ready returns two cycles after accept
      ack_mode = 1;
      exp_beat(32'h100, 32'hA5A5A5A5, 4'b1000);
      issue(32'h103, 32'h0000_00A5, 3'b000, 0);
      #1;
      chk("rdy_busy", 64'(st_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("rdy_back", 64'(st_ready), 64'd1);

      // SW with ack held off for 3 cycles
      ack_mode = 2;
      exp_beat(32'h200, 32'hDEADBEEF, 4'b1111);
      issue(32'h200, 32'hDEADBEEF, 3'b010, 0);

      // Illegal type
      ack_mode = 1;
      err_q.push_back(1'b1);
      issue(32'h40, 32'h1234, 3'b011, 0);

`ifdef STORE_MISALIGN_SPLIT_EN
      exp_beat(32'h100, 32'h33440000, 4'b1100);
      exp_beat(32'h104, 32'h00001122, 4'b0011);
      issue(32'h102, 32'h11223344, 3'b010, 0);
      exp_beat(32'hFFFF_FFFC, 32'hEF000000, 4'b1000);
      exp_beat(32'h0000_0000, 32'h000000BE, 4'b0001);
      issue(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0);
      exp_beat(32'h100, 32'h00BEEF00, 4'b0110);
      issue(32'h101, 32'h0000_BEEF, 3'b001, 0);
`else
      err_q.push_back(1'b1);
      issue(32'h101, 32'h0000_BEEF, 3'b001, 0);
`endif

      // Reset while BEAT0 is waiting for ack
      ack_mode = 3;
      issue(32'h300, 32'hCAFEF00D, 3'b010, 1);
      #1;
      chk("req_before_rst", 64'(mem_req), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 64'(mem_req), 64'd0);
      chk("rst_mid_bmask", 64'(mem_bmask), 64'd0);
      chk("rst_mid_ready", 64'(st_ready), 64'd1);
      beat_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ack_mode = 1;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("no_beat_after_rst", 64'(mem_req), 64'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 120; n++) begin
         ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         issue(ra, $urandom, rt, 1);
      end

      ack_mode = 1;
      guard = 0;
      while ((beat_q.size() > 0 || err_q.size() > 0 || !st_ready) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      chk("drain_beats", 64'(beat_q.size()), 64'd0);
      chk("drain_errs", 64'(err_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, store/memory address width in bits.
REQ-002 SHALL have i_clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have i_st_valid, input, 1: store request from pipeline valid.
REQ-005 SHALL have o_st_ready, output, 1: unit can accept a store.
REQ-006 SHALL have i_st_addr, input, ADDR_W: byte address of store.
REQ-007 SHALL have i_st_data, input, 32: rs2 store data, right-aligned.
REQ-008 SHALL have i_st_type, input, 3: funct3 (000 SB, 001 SH, 010 SW).
REQ-009 SHALL have o_mem_req, output, 1: DMEM write request.
REQ-010 SHALL have i_mem_ack, input, 1: DMEM accepted current write.
REQ-011 SHALL have o_mem_addr, output, ADDR_W: word-aligned write address, low 2 bits always 0.
REQ-012 SHALL have o_mem_wdata, output, 32: lane-positioned write data.
REQ-013 SHALL have o_mem_bmask, output, 4: byte-lane write enables, bit k = byte lane k.
REQ-014 SHALL have o_err, output, 1: one-cycle pulse on rejected store.

Function
REQ-015 SHALL accept a store on a cycle where i_st_valid and o_st_ready are both 1; o_st_ready SHALL be 1 only in state IDLE.
REQ-016 SHALL implement FSM states IDLE, BEAT0, BEAT1; IDLE->BEAT0 on accepted legal store; BEAT0->IDLE on ack if single-beat; BEAT0->BEAT1 on ack if split; BEAT1->IDLE on ack.
REQ-017 SHALL register addr, data and type at acceptance; later input changes SHALL not affect the store in flight.
REQ-018 SHALL assert o_mem_req the cycle after acceptance and hold o_mem_req, o_mem_addr, o_mem_wdata and o_mem_bmask stable until the cycle i_mem_ack is sampled 1.
REQ-019 SHALL form, with off = addr[1:0], an 8-bit mask M = base << off (base 0001 SB, 0011 SH, 1111 SW) and 64-bit data D = i_st_data << (8*off); SB replicates data[7:0], SH uses data[15:0].
REQ-020 SHALL drive BEAT0 with addr {addr[ADDR_W-1:2],00}, mask M[3:0], data D[31:0].
REQ-021 SHALL treat a store as split when M[7:4] != 0; BEAT1 SHALL use word address + 4 (wrapping modulo 2^ADDR_W), mask M[7:4], data D[63:32].
REQ-022 SHALL, in IDLE, drive o_mem_req=0, o_mem_bmask=0, and ignore i_mem_ack.
REQ-023 SHALL reject i_st_type not in {000,001,010}: pulse o_err the cycle after acceptance, stay IDLE, issue no request.
REQ-024 SHALL give minimum throughput of one single-beat store per 2 cycles with ack held 1; o_st_ready returns 1 the cycle after the final ack.
REQ-025 SHALL never issue a request with o_mem_bmask = 0000.

Reset
REQ-026 SHALL, while i_rst_n=0, force state IDLE, o_st_ready=1, o_mem_req=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0, o_err=0, independent of i_clk.
REQ-027 SHALL abandon any in-flight beat on reset assertion; no further beats SHALL issue for that store after release.

Configuration
REQ-028 SHALL use macro STORE_MISALIGN_SPLIT_EN.
REQ-029 SHALL, with STORE_MISALIGN_SPLIT_EN defined, accept any alignment and split word-crossing stores per REQ-021.
REQ-030 SHALL, without it, reject SH with addr[0]=1 and SW with addr[1:0]!=00 as in REQ-023; BEAT1 is unreachable.

Verification
REQ-031 SB addr 0x103, data 0x000000A5, ack next cycle -> one beat addr 0x100, bmask 1000, wdata 0xA5A5A5A5; o_st_ready high 2 cycles after accept.
REQ-032 SW addr 0x200, data 0xDEADBEEF, ack delayed 3 cycles -> outputs stable 3 cycles; addr 0x200, bmask 1111, wdata 0xDEADBEEF.
REQ-033 With macro: SW addr 0x102, data 0x11223344 -> beat0 addr 0x100, bmask 1100, wdata 0x33440000; beat1 addr 0x104, bmask 0011, wdata 0x00001122.
REQ-034 Without macro: SH addr 0x101 -> o_err one-cycle pulse, o_mem_req stays 0; with macro: single beat bmask 0110.
REQ-035 With macro: SH addr 0xFFFFFFFF, data 0xBEEF -> beat0 addr 0xFFFFFFFC bmask 1000 wdata 0xEF000000; beat1 addr 0x00000000 bmask 0001 wdata 0x000000BE.
REQ-036 Type 011 -> o_err pulse, no request; i_rst_n low during BEAT0 wait -> o_mem_req 0 immediately, no beat after release.
